elevator_request_scheduler: RTL

//  Collects floor calls from an 8-floor car and holds them in a pending bitmap.

---
 rtl/elevator_request_scheduler_pkg.sv | 11 +
 rtl/elevator_request_scheduler_floor_picker.sv | 48 ++++
 rtl/elevator_request_scheduler.sv | 111 +++++++++++
 3 files changed

// File: rtl/elevator_request_scheduler_pkg.sv
// Shared types and defaults for the elevator request scheduler.
package elevator_pkg;
   typedef enum logic [1:0] {IDLE, SELECT, MOVE, DOOR} state_t;

   localparam int NUM_FLOORS_DEF  = 8;
   localparam int FLOOR_W_DEF     = 3;
   localparam int DOOR_CYCLES_DEF = 16;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/elevator_request_scheduler_floor_picker.sv
// Combinational LOOK helpers: nearest pending floor above/below the car and
// nearest pending floor strictly between the car and its current target.
module floor_picker import elevator_pkg::*; #(
   parameter int NUM_FLOORS = NUM_FLOORS_DEF,
   parameter int FLOOR_W    = FLOOR_W_DEF
)(
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]    current_floor,
   input  logic [FLOOR_W-1:0]    target_floor,
   input  logic                  dir_up,
   output logic [FLOOR_W-1:0]    above,
   output logic                  above_vld,
   output logic [FLOOR_W-1:0]    below,
   output logic                  below_vld,
   output logic [FLOOR_W-1:0]    ahead,
   output logic                  ahead_vld
);
   logic [31:0] cur, tgt;
   logic [NUM_FLOORS-1:0] above_m, below_m, ahead_m;

   assign cur = 32'(current_floor);
   assign tgt = 32'(target_floor);

   for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_mask
      assign above_m[f] = pending[f] && (32'(f) > cur);
      assign below_m[f] = pending[f] && (32'(f) < cur);
      assign ahead_m[f] = pending[f] && (dir_up ? (32'(f) > cur && 32'(f) < tgt)
                                                : (32'(f) < cur && 32'(f) > tgt));
   end

   // Ascending scan: "keep first" gives the lowest hit, "keep last" the highest.
   always_comb begin
      above = '0; above_vld = 1'b0;
      below = '0; below_vld = 1'b0;
      ahead = '0; ahead_vld = 1'b0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
         if (above_m[f] && !above_vld) begin
            above = FLOOR_W'(f); above_vld = 1'b1;
         end
         if (below_m[f]) begin
            below = FLOOR_W'(f); below_vld = 1'b1;
         end
         if (ahead_m[f] && (!dir_up || !ahead_vld)) begin
            ahead = FLOOR_W'(f); ahead_vld = 1'b1;
         end
      end
   end
endmodule

// File: rtl/elevator_request_scheduler.sv
// LOOK-policy elevator scheduler: pending call bitmap, target selection with
// in-flight retargeting, and door dwell timer.
module elevator_request_scheduler import elevator_pkg::*; #(
   parameter int NUM_FLOORS  = NUM_FLOORS_DEF,
   parameter int FLOOR_W     = FLOOR_W_DEF,
   parameter int DOOR_CYCLES = DOOR_CYCLES_DEF
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] call_req,
   input  logic [FLOOR_W-1:0]    current_floor,
   output logic [FLOOR_W-1:0]    target_floor,
   output logic                  target_valid,
   output logic                  dir_up,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  busy
);
   localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

   state_t                state, state_nxt;
   logic [TW-1:0]         timer, timer_nxt;
   logic [FLOOR_W-1:0]    tgt_nxt, above, below, ahead;
   logic                  tv_nxt, dir_nxt, door_nxt, clr;
   logic                  above_vld, below_vld, ahead_vld;
   logic                  cur_ok, cur_hit;
   logic [NUM_FLOORS-1:0] cur_oh;

   // Out-of-range floors never match and never clear a bit.
   assign cur_ok  = 32'(current_floor) < NUM_FLOORS;
   assign cur_oh  = cur_ok ? (NUM_FLOORS'(1) << current_floor) : '0;
   assign cur_hit = |(pending & cur_oh);

   floor_picker #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_pick (
      .pending(pending), .current_floor(current_floor), .target_floor(target_floor),
      .dir_up(dir_up), .above(above), .above_vld(above_vld), .below(below),
      .below_vld(below_vld), .ahead(ahead), .ahead_vld(ahead_vld)
   );

   always_comb begin
      state_nxt = state;
      tgt_nxt   = target_floor;
      tv_nxt    = target_valid;
      dir_nxt   = dir_up;
      door_nxt  = door_open;
      timer_nxt = timer;
      clr       = 1'b0;
      case (state)
         IDLE: begin
            if (cur_hit) begin
               state_nxt = DOOR; door_nxt = 1'b1;
               timer_nxt = TW'(DOOR_CYCLES - 1); clr = 1'b1;
            end else if (|pending) begin
               state_nxt = SELECT;
            end
         end
         SELECT: begin
            state_nxt = IDLE;
            if (dir_up == DIR_UP) begin
               if (above_vld) tgt_nxt = above;
               else if (below_vld) begin tgt_nxt = below; dir_nxt = DIR_DOWN; end
            end else begin
               if (below_vld) tgt_nxt = below;
               else if (above_vld) begin tgt_nxt = above; dir_nxt = DIR_UP; end
            end
            if (above_vld || below_vld) begin
               tv_nxt = 1'b1; state_nxt = MOVE;
            end
         end
         MOVE: begin
            if (current_floor == target_floor) begin
               state_nxt = DOOR; tv_nxt = 1'b0; door_nxt = 1'b1;
               timer_nxt = TW'(DOOR_CYCLES - 1); clr = 1'b1;
            end else if (ahead_vld) begin
               tgt_nxt = ahead;
            end
         end
         DOOR: begin
            clr = 1'b1;
            if (timer == '0) begin
               state_nxt = IDLE; door_nxt = 1'b0;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         pending      <= '0;
         target_floor <= '0;
         target_valid <= 1'b0;
         dir_up       <= DIR_UP;
         door_open    <= 1'b0;
         timer        <= '0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         pending      <= (pending | call_req) & ~(clr ? cur_oh : '0);
         target_floor <= tgt_nxt;
         target_valid <= tv_nxt;
         dir_up       <= dir_nxt;
         door_open    <= door_nxt;
         timer        <= timer_nxt;
         busy         <= (state_nxt != IDLE);
      end
   end
endmodule
